// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares the single L2 (pmem) port between the I-cache and the D-cache.
// One memory transaction runs at a time; the response is routed back to the
// requester that owns it.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined     -> simultaneous I/D requests alternate (last_grant register,
//                  reset value I, so D wins the first tie after reset)
//   not defined -> fixed priority, D-cache wins every tie
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_read, i_address        I-cache line read request
//   i_rdata, i_resp          I-cache return data / completion pulse
//   d_read, d_write,
//   d_address, d_wdata       D-cache read / write-back request
//   d_rdata, d_resp          D-cache return data / completion pulse
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata memory request (driven from latched state only)
//   pmem_rdata, pmem_resp    memory response
//   dbg_state_o              current FSM state, for checkers
//
// Handshake: a requester raises its request and holds it until its *_resp
// pulse; *_resp is high for exactly the cycle in which pmem_resp is high
// while that requester owns the port. pmem_resp outside a serve state is
// ignored.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  d_req;
  logic                  grant_i, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when the most recent grant went to the D-cache; reset value is I.
  logic                  last_d_q, last_d_d;
`endif

  assign d_req = d_read | d_write;

  // Grant decision, only meaningful in IDLE.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_read && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = ~last_d_q;
        grant_i = last_d_q;
`else
        grant_d = 1'b1;
`endif
      end else begin
        grant_i = i_read;
        grant_d = d_req;
      end
    end
  end

  // Next state and grant-edge latching.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          addr_d  = d_address;
          // d_read and d_write together is illegal; it is served as a write.
          wr_d    = d_write;
          wdata_d = d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (grant_i) begin
          state_d = SERVE_I;
          addr_d  = i_address;
          wr_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  // Memory side comes only from latched registers and state, so requester
  // inputs may change freely once granted.
  assign pmem_read    = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~wr_q);
  assign pmem_write   = (state_q == SERVE_D) & wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: directed scenarios followed by random rounds.
// The driver pushes the expected memory transactions (in the order the
// arbitration rules dictate) into exp_q; a monitor pops and checks them when
// the DUT starts a memory transaction, and checks every response pulse.
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [1:0]    dbg_state;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    bit          owner_d;   // 1: D-cache owns it, 0: I-cache
    bit          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    bit          rel_resp;  // start is 2 cycles after the previous response
    int          issue_cyc; // otherwise 1 cycle after this issue cycle
  } entry_t;

  entry_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;
  int last_resp_cyc = 0;
  logic [LW-1:0] mem_data = '0;
  int mem_mode = 0;         // 0 normal, 1 off, 2 stray responses while idle
  bit model_last_d = 1'b0;  // reference: most recent grant went to D

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- memory model ----------------
  initial begin : memory
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_mode == 0 && (pmem_read || pmem_write)) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        mem_data   = rand_line();
        pmem_rdata = mem_data;
        pmem_resp  = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
      end else if (mem_mode == 2 && !pmem_read && !pmem_write) begin
        @(posedge clk);
        #1;
        mem_data   = rand_line();
        pmem_rdata = mem_data;
        pmem_resp  = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    bit     prev_strobe;
    bit     have;
    bit     strobe;
    entry_t cur;
    prev_strobe = 1'b0;
    have        = 1'b0;
    cur         = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_strobe = 1'b0;
      end else begin
        strobe = pmem_read | pmem_write;
        if (strobe && !prev_strobe) begin
          chk("grant_expected", LW'(exp_q.size() != 0), LW'(1));
          if (exp_q.size() != 0) begin
            cur  = exp_q.pop_front();
            have = 1'b1;
            chk("grant_read", LW'(pmem_read), LW'(!cur.wr));
            chk("grant_write", LW'(pmem_write), LW'(cur.wr));
            chk("grant_cycle", LW'(cyc),
                LW'(cur.rel_resp ? last_resp_cyc + 2 : cur.issue_cyc + 1));
          end
        end
        if (strobe && have) begin
          chk("addr_hold", LW'(pmem_address), LW'(cur.addr));
          if (cur.wr) chk("wdata_hold", pmem_wdata, cur.wdata);
        end
        if (pmem_resp && strobe && have) begin
          chk("i_resp_owner", LW'(i_resp), LW'(!cur.owner_d));
          chk("d_resp_owner", LW'(d_resp), LW'(cur.owner_d));
          chk("rdata", cur.owner_d ? d_rdata : i_rdata, mem_data);
          last_resp_cyc = cyc;
        end else begin
          chk("no_i_resp", LW'(i_resp), LW'(0));
          chk("no_d_resp", LW'(d_resp), LW'(0));
        end
        prev_strobe = strobe;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one round of requests (kind 0: I only, 1: D only, 2: both) and
  // holds each request until its response. Called at posedge+1.
  task automatic do_round(input int kind, input bit scramble,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [LW-1:0] dw, input bit wr, input bit illegal);
    entry_t ei, ed;
    bit want_i, want_d, got_i, got_d, d_first;
    int t;
    want_i = (kind != 1);
    want_d = (kind != 0);
    got_i  = 1'b0;
    got_d  = 1'b0;
    ei = '0;
    ei.owner_d = 1'b0; ei.wr = 1'b0; ei.addr = ia; ei.issue_cyc = cyc;
    ed = '0;
    ed.owner_d = 1'b1; ed.wr = wr; ed.addr = da; ed.wdata = dw; ed.issue_cyc = cyc;

    i_read    = want_i;
    i_address = ia;
    d_write   = want_d && wr;
    d_read    = want_d && (!wr || illegal);
    d_address = da;
    d_wdata   = dw;

    if (want_i && want_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      d_first = !model_last_d;
`else
      d_first = 1'b1;
`endif
      if (d_first) begin
        ei.rel_resp = 1'b1;
        exp_q.push_back(ed);
        exp_q.push_back(ei);
      end else begin
        ed.rel_resp = 1'b1;
        exp_q.push_back(ei);
        exp_q.push_back(ed);
      end
      model_last_d = !d_first;
    end else if (want_i) begin
      exp_q.push_back(ei);
      model_last_d = 1'b0;
    end else begin
      exp_q.push_back(ed);
      model_last_d = 1'b1;
    end

    if (scramble) begin
      @(posedge clk);
      #1;
      if (want_i) i_address = 32'h0000_0200;
      if (want_d) begin
        d_address = ~da;
        d_wdata   = ~dw;
      end
    end

    t = 0;
    while ((want_i && !got_i) || (want_d && !got_d)) begin
      @(negedge clk);
      if (i_resp) got_i = 1'b1;
      if (d_resp) got_d = 1'b1;
      @(posedge clk);
      #1;
      if (got_i) i_read = 1'b0;
      if (got_d) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
      t++;
      if (t > 60) begin
        chk("resp_timeout", LW'(0), LW'(1));
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        exp_q.delete();
        break;
      end
    end
  endtask

  // D write-back interrupted by reset two cycles into service, then stray
  // memory responses while idle.
  task automatic reset_mid_txn();
    entry_t ed;
    mem_mode = 1;
    ed = '0;
    ed.owner_d = 1'b1; ed.wr = 1'b1; ed.addr = $urandom; ed.wdata = rand_line();
    ed.issue_cyc = cyc;
    d_write   = 1'b1;
    d_address = ed.addr;
    d_wdata   = ed.wdata;
    exp_q.push_back(ed);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    d_write = 1'b0;
    model_last_d = 1'b0;
    @(negedge clk);
    chk("rst_pmem_write", LW'(pmem_write), LW'(0));
    chk("rst_pmem_read", LW'(pmem_read), LW'(0));
    chk("rst_d_resp", LW'(d_resp), LW'(0));
    @(posedge clk);
    #1 mem_mode = 2;
    repeat (5) @(posedge clk);
    #1 mem_mode = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int kind;
    bit wr, scr, ill;
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pmem_read", LW'(pmem_read), LW'(0));
    chk("reset_pmem_write", LW'(pmem_write), LW'(0));
    chk("reset_pmem_address", LW'(pmem_address), LW'(0));
    chk("reset_pmem_wdata", pmem_wdata, LW'(0));
    chk("reset_i_resp", LW'(i_resp), LW'(0));
    chk("reset_d_resp", LW'(d_resp), LW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    model_last_d = 1'b0;
    @(posedge clk);
    #1;

    // Single I read at 0x60, address changed to 0x200 while served.
    do_round(0, 1'b1, 32'h0000_0060, '0, '0, 1'b0, 1'b0);
    // D write-back of a DEAD..BEEF line.
    do_round(1, 1'b1, '0, 32'h0000_1000, {8{32'hDEAD_BEEF}}, 1'b1, 1'b0);
    // Three rounds with both requesting: order follows the arbitration mode.
    for (int r = 0; r < 3; r++)
      do_round(2, 1'b0, $urandom, $urandom, rand_line(), r[0], 1'b0);
    // Illegal read+write together is served as a write.
    do_round(1, 1'b0, '0, $urandom, rand_line(), 1'b1, 1'b1);

    reset_mid_txn();

    for (int r = 0; r < 60; r++) begin
      kind = $urandom_range(0, 2);
      wr   = $urandom_range(0, 1);
      ill  = wr && ($urandom_range(0, 3) == 0);
      scr  = (kind != 2) && ($urandom_range(0, 1) == 1);
      do_round(kind, scr, $urandom, $urandom, rand_line(), wr, ill);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    chk("exp_q_drained", LW'(exp_q.size()), LW'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
